cpu_fpu_div_sequencer: RTL and testbench

//  Upstream front-end of the FPU divider. Takes FDIV.S requests from the execute stage and classifies the operands.

---
 rtl/cpu_fpu_div_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cpu_fpu_div_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fpu_div_sequencer.sv
// cpu_fpu_div_sequencer: FDIV.S front-end that classifies operands, resolves special cases locally,
// sequences the divider hold-request/ready handshake and returns quotient, tag and fflags.
//   i_clock, i_reset_n           clock, asynchronous active-low reset
//   i_request/o_accept           operation offer from execute (taken only in IDLE)
//   i_op1, i_op2, i_tag          dividend, divisor, pass-through tag
//   i_kill                       squash the in-flight operation
//   o_div_request/o_div_op1/2    request and stable operands to the divider
//   i_div_ready/i_div_result     divider result strobe (level) and quotient
//   o_valid/i_result_ack         result handshake to writeback
//   o_result, o_tag, o_flags     quotient, tag, {NV,DZ,OF,UF,NX}
//   o_fault                      sticky divider-timeout indicator
module cpu_fpu_div_sequencer #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_request,
    output logic             o_accept,
    input  logic [31:0]      i_op1,
    input  logic [31:0]      i_op2,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_kill,
    output logic             o_div_request,
    output logic [31:0]      o_div_op1,
    output logic [31:0]      o_div_op2,
    input  logic             i_div_ready,
    input  logic [31:0]      i_div_result,
    output logic             o_valid,
    input  logic             i_result_ack,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic [4:0]       o_flags,
    output logic             o_fault
);
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [2:0] C_ZERO = 3'd0, C_SUB = 3'd1, C_NORM = 3'd2, C_INF = 3'd3, C_QNAN = 3'd4, C_SNAN = 3'd5;

    typedef enum logic [2:0] {IDLE, CLASSIFY, FAST, DIV_REQ, DIV_DRAIN, RESULT} state_t;

    state_t            state, next_state;
    logic [31:0]       op1, op2, result_q, fast_res;
    logic [TAG_W-1:0]  tag_q;
    logic [2:0]        c1, c2, cls1_d, cls2_d;
    logic [4:0]        flags_q, fast_flags;
    logic [CW-1:0]     cnt;
    logic              fault_q, valid_q, killed, special, timeout, sign, of, uf;
    logic              nan1, nan2, snan1, snan2, inf1, inf2, zero1, zero2;

    function automatic logic [2:0] classify(input logic [31:0] x);
        return (x[30:23] == 8'hFF) ? ((x[22:0] == '0) ? C_INF : x[22] ? C_QNAN : C_SNAN)
             : (x[30:23] == 8'h00) ? ((x[22:0] == '0) ? C_ZERO : C_SUB) : C_NORM;
    endfunction

    assign cls1_d  = classify(op1);
    assign cls2_d  = classify(op2);
    // subnormals are finite non-zero and are left to the divider
    assign special = !(cls1_d == C_SUB || cls1_d == C_NORM) || !(cls2_d == C_SUB || cls2_d == C_NORM);
    assign timeout = (cnt == CW'(TIMEOUT));
    assign sign    = op1[31] ^ op2[31];
    assign snan1   = (c1 == C_SNAN);
    assign snan2   = (c2 == C_SNAN);
    assign nan1    = snan1 || (c1 == C_QNAN);
    assign nan2    = snan2 || (c2 == C_QNAN);
    assign inf1    = (c1 == C_INF);
    assign inf2    = (c2 == C_INF);
    assign zero1   = (c1 == C_ZERO);
    assign zero2   = (c2 == C_ZERO);
    assign of      = (i_div_result[30:23] == 8'hFF);
    assign uf      = (i_div_result[30:23] == 8'h00);

    // special-case result, rules in priority order
    always_comb begin
        fast_res   = QNAN;
        fast_flags = 5'b00000;
        if (nan1 || nan2)
            fast_flags = {snan1 || snan2, 4'b0000};
        else if ((inf1 && inf2) || (zero1 && zero2))
            fast_flags = 5'b10000;
        else if (inf1)
            fast_res = {sign, 8'hFF, 23'd0};
        else if (inf2 || zero1)
            fast_res = {sign, 31'd0};
        else begin
            fast_res   = {sign, 8'hFF, 23'd0};
            fast_flags = 5'b01000;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // a killed divide still finishes its handshake; it only leaves DIV_DRAIN without a result
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = i_request ? CLASSIFY : IDLE;
            CLASSIFY:  next_state = i_kill ? IDLE : special ? FAST : DIV_REQ;
            FAST:      next_state = i_kill ? IDLE : RESULT;
            DIV_REQ:   next_state = (i_div_ready || timeout) ? DIV_DRAIN : DIV_REQ;
            DIV_DRAIN: next_state = i_div_ready ? DIV_DRAIN : (killed || i_kill) ? IDLE : RESULT;
            RESULT:    next_state = (i_kill || (i_result_ack && valid_q)) ? IDLE : RESULT;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        o_accept      = (state == IDLE);
        o_div_request = (state == DIV_REQ);
    end

    // o_valid rises one cycle after RESULT is entered and falls on the ack/kill edge
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            op1      <= '0;
            op2      <= '0;
            tag_q    <= '0;
            c1       <= C_ZERO;
            c2       <= C_ZERO;
            cnt      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            fault_q  <= 1'b0;
            valid_q  <= 1'b0;
            killed   <= 1'b0;
        end else begin
            valid_q <= (state == RESULT) && (next_state == RESULT);
            if (state == IDLE && i_request) begin
                op1    <= i_op1;
                op2    <= i_op2;
                tag_q  <= i_tag;
                killed <= 1'b0;
            end
            if (state == CLASSIFY) begin
                c1  <= cls1_d;
                c2  <= cls2_d;
                cnt <= '0;
            end
            if (state == FAST) begin
                result_q <= fast_res;
                flags_q  <= fast_flags;
            end
            if (state == DIV_REQ) begin
                cnt <= cnt + 1'b1;
                if (i_div_ready) begin
                    result_q <= i_div_result;
                    flags_q  <= {2'b00, of, uf, of | uf};
                end else if (timeout) begin
                    result_q <= QNAN;
                    flags_q  <= 5'b10000;
                    fault_q  <= 1'b1;
                end
            end
            if (state == DIV_REQ || state == DIV_DRAIN)
                killed <= killed | i_kill;
        end
    end

    assign o_div_op1 = op1;
    assign o_div_op2 = op2;
    assign o_valid   = valid_q;
    assign o_result  = result_q;
    assign o_tag     = tag_q;
    assign o_flags   = flags_q;
    assign o_fault   = fault_q;
endmodule

// File: tb/tb_cpu_fpu_div_sequencer.sv
// tb_cpu_fpu_div_sequencer: directed self-checking bench for the FDIV.S sequencer with a behavioural divider.
module tb_cpu_fpu_div_sequencer;
    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_request = 1'b0;
    logic        o_accept;
    logic [31:0] i_op1 = '0;
    logic [31:0] i_op2 = '0;
    logic [4:0]  i_tag = '0;
    logic        i_kill = 1'b0;
    logic        o_div_request;
    logic [31:0] o_div_op1, o_div_op2;
    logic        i_div_ready = 1'b0;
    logic [31:0] i_div_result = '0;
    logic        o_valid;
    logic        i_result_ack = 1'b0;
    logic [31:0] o_result;
    logic [4:0]  o_tag;
    logic [4:0]  o_flags;
    logic        o_fault;

    int          tests = 0;
    int          fails = 0;
    int          n, req_cycles, bad;
    logic        saw, v, early, rdy_seen;
    logic [31:0] req_op1, req_op2;
    logic        div_en = 1'b1;
    int          div_lat = 3;
    logic [31:0] div_res = '0;
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    logic [4:0]  vf [8];

    cpu_fpu_div_sequencer #(.TAG_W(5), .TIMEOUT(255)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_request(i_request), .o_accept(o_accept),
        .i_op1(i_op1), .i_op2(i_op2), .i_tag(i_tag), .i_kill(i_kill),
        .o_div_request(o_div_request), .o_div_op1(o_div_op1), .o_div_op2(o_div_op2),
        .i_div_ready(i_div_ready), .i_div_result(i_div_result), .o_valid(o_valid),
        .i_result_ack(i_result_ack), .o_result(o_result), .o_tag(o_tag), .o_flags(o_flags),
        .o_fault(o_fault)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // divider: ready after div_lat cycles of request, held three cycles after request drops
    initial begin
        int lat_cnt, hold_cnt;
        lat_cnt = 0;
        hold_cnt = 0;
        forever begin
            @(posedge i_clock);
            #2;
            if (div_en && o_div_request && !i_div_ready) begin
                if (lat_cnt == div_lat) begin
                    i_div_ready = 1'b1;
                    i_div_result = div_res;
                    lat_cnt = 0;
                end else
                    lat_cnt++;
            end else if (i_div_ready && !o_div_request) begin
                if (hold_cnt == 2) begin
                    i_div_ready = 1'b0;
                    hold_cnt = 0;
                end else
                    hold_cnt++;
            end else if (!o_div_request)
                lat_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        i_op1 = a;
        i_op2 = b;
        i_tag = t;
        i_request = 1'b1;
        tick();
        i_request = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        n = 0;
        saw = 1'b0;
        req_cycles = 0;
        while (!o_valid && n < max) begin
            if (o_div_request) begin
                saw = 1'b1;
                req_cycles++;
                req_op1 = o_div_op1;
                req_op2 = o_div_op2;
            end
            tick();
            n++;
        end
        chk("valid_seen", {31'd0, o_valid}, 32'd1);
    endtask

    task automatic ack();
        i_result_ack = 1'b1;
        tick();
        i_result_ack = 1'b0;
        chk("valid_drop", {31'd0, o_valid}, 32'd0);
        chk("accept_back", {31'd0, o_accept}, 32'd1);
    endtask

    initial begin
        va = '{32'h00000000, 32'h7F800001, 32'h7FC00000, 32'hFF800000, 32'h3F800000, 32'h80000000, 32'h7F800000, 32'h7FC00000};
        vb = '{32'h80000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'hFF800000, 32'h3F800000, 32'h7F800000, 32'h7F800001};
        vr = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000, 32'h7FC00000, 32'h7FC00000};
        vf = '{5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b10000};

        tick();
        tick();
        chk("rst_accept", {31'd0, o_accept}, 32'd1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_divreq", {31'd0, o_div_request}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_tag", {27'd0, o_tag}, 32'd0);
        chk("rst_flags", {27'd0, o_flags}, 32'd0);
        chk("rst_fault", {31'd0, o_fault}, 32'd0);
        chk("rst_op1", o_div_op1, 32'd0);
        i_reset_n = 1'b1;
        tick();

        // 6 / 2 through the divider
        div_res = 32'h40400000;
        issue(32'h40C00000, 32'h40000000, 5'd9);
        chk("t1_accept_low", {31'd0, o_accept}, 32'd0);
        wait_valid(50);
        chk("t1_divreq_seen", {31'd0, saw}, 32'd1);
        chk("t1_div_op1", req_op1, 32'h40C00000);
        chk("t1_div_op2", req_op2, 32'h40000000);
        chk("t1_drained", {31'd0, i_div_ready}, 32'd0);
        chk("t1_result", o_result, 32'h40400000);
        chk("t1_flags", {27'd0, o_flags}, 32'd0);
        chk("t1_tag", {27'd0, o_tag}, 32'd9);
        ack();

        // 1 / 0 on the fast path
        issue(32'h3F800000, 32'h00000000, 5'd3);
        wait_valid(10);
        chk("t2_latency", n, 32'd3);
        chk("t2_no_divreq", {31'd0, saw}, 32'd0);
        chk("t2_result", o_result, 32'h7F800000);
        chk("t2_flags", {27'd0, o_flags}, 32'b01000);
        chk("t2_tag", {27'd0, o_tag}, 32'd3);
        ack();

        for (int i = 0; i < 8; i++) begin
            issue(va[i], vb[i], 5'(i));
            wait_valid(10);
            chk($sformatf("t3_result_%0d", i), o_result, vr[i]);
            chk($sformatf("t3_flags_%0d", i), {27'd0, o_flags}, {27'd0, vf[i]});
            ack();
        end

        // divider overflow and a subnormal dividend that must go to the divider
        div_res = 32'h7F800000;
        issue(32'h7F000000, 32'h00800000, 5'd1);
        wait_valid(50);
        chk("of_result", o_result, 32'h7F800000);
        chk("of_flags", {27'd0, o_flags}, 32'b00101);
        ack();
        div_res = 32'h00000001;
        issue(32'h00000001, 32'h3F800000, 5'd2);
        wait_valid(50);
        chk("uf_divreq_seen", {31'd0, saw}, 32'd1);
        chk("uf_flags", {27'd0, o_flags}, 32'b00011);
        ack();

        // kill while classifying
        issue(32'h3F800000, 32'h00000000, 5'd2);
        i_kill = 1'b1;
        tick();
        i_kill = 1'b0;
        v = 1'b0;
        repeat (6) begin
            v |= o_valid;
            tick();
        end
        chk("kcls_no_valid", {31'd0, v}, 32'd0);
        chk("kcls_accept", {31'd0, o_accept}, 32'd1);

        // kill while the divider request is pending
        div_lat = 5;
        div_res = 32'h40400000;
        issue(32'h40C00000, 32'h40000000, 5'd4);
        tick();
        chk("t4_divreq", {31'd0, o_divreq_bit()}, 32'd1);
        i_kill = 1'b1;
        tick();
        i_kill = 1'b0;
        v = 1'b0;
        early = 1'b0;
        rdy_seen = 1'b0;
        n = 0;
        while (!o_accept && n < 60) begin
            v |= o_valid;
            rdy_seen |= i_div_ready;
            if (!o_div_request && !rdy_seen)
                early = 1'b1;
            tick();
            n++;
        end
        chk("t4_back_idle", {31'd0, o_accept}, 32'd1);
        chk("t4_no_valid", {31'd0, v}, 32'd0);
        chk("t4_req_held", {31'd0, early}, 32'd0);
        chk("t4_ready_seen", {31'd0, rdy_seen}, 32'd1);
        chk("t4_drained", {31'd0, i_div_ready}, 32'd0);
        div_res = 32'h40000000;
        issue(32'h41200000, 32'h40A00000, 5'd6);
        wait_valid(50);
        chk("t4_next_result", o_result, 32'h40000000);
        chk("t4_next_tag", {27'd0, o_tag}, 32'd6);
        ack();

        // result held without ack; a new request must be ignored
        issue(32'h3F800000, 32'h00000000, 5'd11);
        wait_valid(10);
        i_request = 1'b1;
        i_op1 = 32'h40C00000;
        i_op2 = 32'h40000000;
        i_tag = 5'd1;
        bad = 0;
        repeat (20) begin
            tick();
            if (o_valid !== 1'b1 || o_result !== 32'h7F800000 || o_tag !== 5'd11 || o_accept !== 1'b0 || o_flags !== 5'b01000)
                bad++;
        end
        chk("t5_hold_stable", bad, 32'd0);
        i_request = 1'b0;
        ack();
        tick();
        chk("t5_req_ignored", {31'd0, o_accept}, 32'd1);

        // divider never answers
        div_en = 1'b0;
        issue(32'h40C00000, 32'h40000000, 5'd12);
        wait_valid(400);
        chk("t6_req_cycles", req_cycles, 32'd256);
        chk("t6_result", o_result, 32'h7FC00000);
        chk("t6_flags", {27'd0, o_flags}, 32'b10000);
        chk("t6_fault", {31'd0, o_fault}, 32'd1);
        ack();
        issue(32'h40C00000, 32'h40000000, 5'd13);
        repeat (3) tick();
        chk("t6_divreq2", {31'd0, o_div_request}, 32'd1);
        chk("t6_fault_sticky", {31'd0, o_fault}, 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("t6_rst_divreq", {31'd0, o_div_request}, 32'd0);
        chk("t6_rst_fault", {31'd0, o_fault}, 32'd0);
        chk("t6_rst_accept", {31'd0, o_accept}, 32'd1);
        chk("t6_rst_tag", {27'd0, o_tag}, 32'd0);
        chk("t6_rst_result", o_result, 32'd0);
        chk("t6_rst_op1", o_div_op1, 32'd0);
        tick();
        i_reset_n = 1'b1;
        tick();
        chk("t6_after_rst_valid", {31'd0, o_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic logic o_divreq_bit();
        return o_div_request;
    endfunction
endmodule
